// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps an external 8:1 registered mux through the channels
// set in a captured mask, waits SETTLE_CYCLES after each select change, samples
// Y into data_out and pulses done once the mask is exhausted.
//
// Optional feature: define SCAN_COMPL_CHECK_EN to flag err whenever Yn == Y at
// a sample point (sticky until the next accepted start). Without it, err is 0
// and Yn is ignored.
//
// Ports:
//   clk_in      sole clock, rising edge (also the mux register clock)
//   reset_n     asynchronous active-low reset
//   start       scan request, honoured in IDLE only
//   abort       synchronous scan cancel
//   chan_mask   channels to scan, captured when start is accepted
//   Y, Yn       mux true / complement outputs
//   S           mux channel select
//   LE          mux register load enable
//   OE1, OE2    mux output enables, active-low
//   OE3         mux output enable, active-high
//   busy, done  scan in progress / one-cycle completion pulse
//   data_out    sampled Y per channel
//   err         complement-check failure flag
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] chan_mask,
  input  logic       Y,
  input  logic       Yn,
  output logic [2:0] S,
  output logic       LE,
  output logic       OE1,
  output logic       OE2,
  output logic       OE3,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out,
  output logic       err
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] SETTLE_LAST =
    CW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LATCH, SELECT, SETTLE, SAMPLE, DONE} state_t;

  state_t        state, state_nx;
  logic [7:0]    mask, mask_nx, data_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    s_nx;
  logic          err_nx, le_nx, oe_nx, busy_nx, done_nx;

  // Index of the lowest set bit (0 when none set).
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest = 3'(i);
    end
  endfunction

  // Next state, datapath and output decode; outputs are registered from state_nx.
  always_comb begin
    state_nx = state;
    mask_nx  = mask;
    data_nx  = data_out;
    cnt_nx   = cnt;
    err_nx   = err;
    s_nx     = S;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          mask_nx  = chan_mask;
          data_nx  = '0;
          err_nx   = 1'b0;
          state_nx = (chan_mask == 8'h00) ? DONE : LATCH;
        end
      end
      LATCH: begin
        state_nx = SELECT;
        s_nx     = lowest(mask);
      end
      SELECT: begin
        cnt_nx   = '0;
        state_nx = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) state_nx = SAMPLE;
        else                    cnt_nx   = cnt + CW'(1);
      end
      SAMPLE: begin
        data_nx[S] = Y;
        mask_nx[S] = 1'b0;
`ifdef SCAN_COMPL_CHECK_EN
        if (Yn == Y) err_nx = 1'b1;
`endif
        state_nx = (mask_nx != 8'h00) ? SELECT : DONE;
        s_nx     = lowest(mask_nx);
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Abort wins over any transition while a scan is running.
    if (abort && busy) begin
      state_nx = IDLE;
      mask_nx  = '0;
      data_nx  = '0;
      cnt_nx   = '0;
    end

`ifndef SCAN_COMPL_CHECK_EN
    err_nx = 1'b0;
`endif

    le_nx   = (state_nx == LATCH);
    busy_nx = (state_nx == LATCH) || (state_nx == SELECT) ||
              (state_nx == SETTLE) || (state_nx == SAMPLE);
    oe_nx   = (state_nx == SELECT) || (state_nx == SETTLE) || (state_nx == SAMPLE);
    done_nx = (state_nx == DONE);
    if (!oe_nx) s_nx = '0;
  end

`ifndef SCAN_COMPL_CHECK_EN
  logic unused_yn;
  assign unused_yn = Yn;
`endif

  // State and registered outputs.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mask     <= '0;
      cnt      <= '0;
      S        <= '0;
      LE       <= 1'b0;
      OE1      <= 1'b1;
      OE2      <= 1'b1;
      OE3      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      mask     <= mask_nx;
      cnt      <= cnt_nx;
      S        <= s_nx;
      LE       <= le_nx;
      OE1      <= ~oe_nx;
      OE2      <= ~oe_nx;
      OE3      <= oe_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      data_out <= data_nx;
      err      <= err_nx;
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a cycle-indexed model of the scan timeline is
// checked against the DUT on every falling edge, plus directed scenarios with
// hand-computed results (full scan, sparse mask, empty mask, abort, async
// reset, complement check when SCAN_COMPL_CHECK_EN is defined).
module tb_mux_scan_sequencer;

  localparam int unsigned SC = 2;
  localparam int P = SC + 2;   // cycles spent per channel

  logic       clk_in  = 1'b0;
  logic       reset_n = 1'b1;
  logic       start, abort;
  logic [7:0] chan_mask;
  logic       Y, Yn;
  logic [2:0] S;
  logic       LE, OE1, OE2, OE3, busy, done, err;
  logic [7:0] data_out;

  logic [7:0] ypat  = 8'h00;   // Y value each channel presents
  logic [7:0] ynbad = 8'h00;   // channels whose Yn wrongly equals Y

  assign Y  = ypat[S];
  assign Yn = ynbad[S] ? ypat[S] : ~ypat[S];

  mux_scan_sequencer #(.SETTLE_CYCLES(SC)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .start(start), .abort(abort),
    .chan_mask(chan_mask), .Y(Y), .Yn(Yn), .S(S), .LE(LE), .OE1(OE1),
    .OE2(OE2), .OE3(OE3), .busy(busy), .done(done), .data_out(data_out),
    .err(err)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] outs();
    return {S, LE, OE1, OE2, OE3, busy, done, data_out, err};
  endfunction

  localparam logic [17:0] RESET_OUTS = 18'h03000;

  // Model: mk is the cycle index since the accepting edge (0 = idle).
  int         mk = 0;
  int         mn = 0;
  int         chans [8];
  logic [7:0] mdata = 8'h00;
  logic       merr  = 1'b0;

  function automatic int last_cycle();
    return (mn == 0) ? 1 : 2 + mn * P;
  endfunction

  always @(posedge clk_in or negedge reset_n) begin
    int ch;
    if (!reset_n) begin
      mk = 0; mdata = 8'h00; merr = 1'b0;
    end else if (mk == 0) begin
      if (start && !abort) begin
        mn = 0;
        for (int i = 0; i < 8; i++) if (chan_mask[i]) begin chans[mn] = i; mn++; end
        mdata = 8'h00; merr = 1'b0; mk = 1;
      end
    end else if (mk == last_cycle()) begin
      mk = 0;
    end else if (abort) begin
      mk = 0; mdata = 8'h00;
    end else begin
      if (mk >= 2 && (mk - 2) % P == P - 1) begin
        ch = chans[(mk - 2) / P];
        mdata[ch] = ypat[ch];
`ifdef SCAN_COMPL_CHECK_EN
        if (ynbad[ch]) merr = 1'b1;
`endif
      end
      mk++;
    end
  end

  // Per-cycle comparison against the model.
  bit chk_en = 1'b0;
  always @(negedge clk_in) begin
    logic [17:0] exp, care;
    if (chk_en) begin
      care = '1;
      if (mk == 0 || mk == last_cycle())
        exp = {3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (mk != 0), mdata, merr};
      else if (mk == 1) begin
        exp  = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, mdata, merr};
        care[17:15] = 3'b000;   // select is not defined while latching
      end else
        exp = {3'(chans[(mk - 2) / P]), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mdata, merr};
      chk("cycle_model", 32'(outs() & care), 32'(exp & care));
    end
  end

  // Runs one scan; reports done cycle (-1 on timeout), channels visited, LE pulses.
  task automatic run_scan(input logic [7:0] m, output int dc,
                          output logic [7:0] seen, output int le_cnt);
    @(posedge clk_in); #1 start = 1'b1; chan_mask = m;
    @(posedge clk_in); #1 start = 1'b0; chan_mask = ~m;
    dc = -1; seen = 8'h00; le_cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk_in);
      if (LE) le_cnt++;
      if (busy && !LE) seen[S] = 1'b1;
      if (done) begin dc = k; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dc, le_cnt, dn;
    logic [7:0] seen;
    logic exp_err;
    start = 1'b0; abort = 1'b0; chan_mask = 8'h00;
    #1 reset_n = 1'b0;
    #2 chk("reset_outs", 32'(outs()), 32'(RESET_OUTS));
    repeat (2) @(posedge clk_in);
    #1 reset_n = 1'b1; chk_en = 1'b1;

    // Full scan, Y = bit S of A5.
    ypat = 8'hA5;
    run_scan(8'hFF, dc, seen, le_cnt);
    chk("full_done_cycle", 32'(dc), 32'd34);
    chk("full_seen", 32'(seen), 32'hFF);
    chk("full_le", 32'(le_cnt), 32'd1);
    chk("full_data", 32'(data_out), 32'hA5);
    repeat (3) @(negedge clk_in);
    chk("full_hold", 32'(data_out), 32'hA5);

    // Sparse mask, Y always 1.
    ypat = 8'hFF;
    run_scan(8'h12, dc, seen, le_cnt);
    chk("sparse_done_cycle", 32'(dc), 32'd10);
    chk("sparse_seen", 32'(seen), 32'h12);
    chk("sparse_le", 32'(le_cnt), 32'd1);
    chk("sparse_data", 32'(data_out), 32'h12);

    // Empty mask.
    run_scan(8'h00, dc, seen, le_cnt);
    chk("empty_done_cycle", 32'(dc), 32'd1);
    chk("empty_le", 32'(le_cnt), 32'd0);
    chk("empty_data", 32'(data_out), 32'h00);

    // Abort in cycle 5, start in cycle 3 ignored.
    ypat = 8'hA5;
    @(posedge clk_in); #1 start = 1'b1; chan_mask = 8'hFF;
    @(posedge clk_in); #1 start = 1'b0; chan_mask = 8'h00;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1 start = 1'b1;
    @(posedge clk_in); #1 start = 1'b0;
    @(posedge clk_in); #1 abort = 1'b1;
    @(posedge clk_in); #1 abort = 1'b0;
    chk("abort_idle", 32'(outs()), 32'(RESET_OUTS));
    dn = 0;
    repeat (40) begin @(negedge clk_in); if (done) dn++; end
    chk("abort_no_done", 32'(dn), 32'd0);

    // Abort together with start in IDLE: start is dropped.
    @(posedge clk_in); #1 start = 1'b1; abort = 1'b1; chan_mask = 8'hFF;
    @(posedge clk_in); #1 start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", 32'(outs()), 32'(RESET_OUTS));

    // Complement check: Yn == Y on channel 3 only.
    ypat = 8'h5A; ynbad = 8'h08;
`ifdef SCAN_COMPL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_scan(8'hFF, dc, seen, le_cnt);
    chk("compl_err", 32'(err), 32'(exp_err));
    chk("compl_data", 32'(data_out), 32'h5A);
    ynbad = 8'h00;
    @(posedge clk_in); #1 start = 1'b1; chan_mask = 8'h01;
    @(posedge clk_in); #1 start = 1'b0;
    chk("compl_err_cleared", 32'(err), 32'd0);
    repeat (10) @(posedge clk_in);

    // Async reset in the middle of SETTLE.
    ypat = 8'hFF;
    @(posedge clk_in); #1 start = 1'b1; chan_mask = 8'hFF;
    @(posedge clk_in); #1 start = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in); #2 reset_n = 1'b0;
    #1 chk("reset_async", 32'(outs()), 32'(RESET_OUTS));
    repeat (2) @(posedge clk_in);
    #1 reset_n = 1'b1;
    dn = 0;
    repeat (40) begin @(negedge clk_in); if (done) dn++; end
    chk("reset_no_done", 32'(dn), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, range 0..15: clk_in cycles between select change and Y sample.
REQ-002 SHALL have port clk_in  input  1  sole clock, rising edge; also drives the mux register CP.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  scan request, sampled in IDLE only.
REQ-005 SHALL have port abort  input  1  synchronous scan cancel.
REQ-006 SHALL have port chan_mask  input  8  channels to scan, captured at start acceptance.
REQ-007 SHALL have ports Y, Yn  input  1 each  mux true/complement outputs.
REQ-008 SHALL have port S  output  3  mux channel select.
REQ-009 SHALL have port LE  output  1  mux register load enable.
REQ-010 SHALL have ports OE1, OE2  output  1 each  mux output enables, active-low.
REQ-011 SHALL have port OE3  output  1  mux output enable, active-high.
REQ-012 SHALL have ports busy, done  output  1 each  scan in progress; one-cycle completion pulse.
REQ-013 SHALL have port data_out  output  8  sampled Y per channel.
REQ-014 SHALL have port err  output  1  complement-check failure flag.

Function
REQ-015 SHALL implement states IDLE, LATCH, SELECT, SETTLE, SAMPLE, DONE.
REQ-016 IDLE: busy=0, LE=0, outputs disabled (OE1=1, OE2=1, OE3=0), S=0; start=1 -> LATCH, capture chan_mask into work mask, clear data_out and err.
REQ-017 start=1 with chan_mask=0 SHALL go IDLE -> DONE directly, data_out=0.
REQ-018 LATCH: LE=1 for exactly one cycle, then SELECT.
REQ-019 SELECT: S = index of lowest set bit in work mask, outputs enabled (OE1=0, OE2=0, OE3=1) from SELECT through SAMPLE; one cycle; -> SETTLE, or -> SAMPLE if SETTLE_CYCLES=0.
REQ-020 SETTLE: hold S for exactly SETTLE_CYCLES cycles, then SAMPLE.
REQ-021 SAMPLE: data_out[S] <= Y, clear bit S in work mask; remaining mask nonzero -> SELECT, else DONE.
REQ-022 DONE: done=1 one cycle, busy=0, outputs disabled, -> IDLE; data_out holds until next accepted start.
REQ-023 busy SHALL be 1 in LATCH, SELECT, SETTLE, SAMPLE.
REQ-024 Latency: with N masked channels, done SHALL be high in cycle 2+N*(2+SETTLE_CYCLES) after the accepting edge (N=0: cycle 1).
REQ-025 data_out bits of unmasked channels SHALL read 0.
REQ-026 start while busy SHALL be ignored; chan_mask changes after acceptance SHALL have no effect.
REQ-027 abort=1 in any busy state SHALL return to IDLE next cycle, clear data_out, no done pulse; abort has priority over state transitions; abort in IDLE/DONE ignored, abort with start in IDLE -> start ignored.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE: S=0, LE=0, OE1=1, OE2=1, OE3=0, busy=0, done=0, data_out=0, err=0, work mask=0, settle counter=0.
REQ-029 Reset mid-scan SHALL discard the scan; no done pulse on release.

Configuration
REQ-030 With macro SCAN_COMPL_CHECK_EN defined, SAMPLE SHALL set err (sticky until next accepted start) when Yn equals Y.
REQ-031 Without SCAN_COMPL_CHECK_EN, err SHALL be constant 0 and Yn unused.

Verification
REQ-032 Reset, start with chan_mask=8'hFF, Y driven = bit S of 8'hA5, SETTLE_CYCLES=2 -> S steps 0..7, LE one pulse, done in cycle 34, data_out=8'hA5.
REQ-033 chan_mask=8'h12, Y=1 always -> S visits 1 then 4 only, done in cycle 10, data_out=8'h12.
REQ-034 chan_mask=8'h00 -> done in cycle 1, LE never asserted, data_out=8'h00.
REQ-035 abort in cycle 5 of full scan -> IDLE in cycle 6, busy=0, no done, data_out=8'h00; start in cycle 3 of scan ignored.
REQ-036 SCAN_COMPL_CHECK_EN defined, Yn=Y on channel 3 only -> err=1 at done, cleared on next start.
REQ-037 reset_n low mid-SETTLE -> all outputs at reset values asynchronously, no done after release.
